// File: rtl/aes_pkg.sv
// -----------------------------------------------------------------------------
// aes_pkg
// Shared AES GF(2^8) helpers for the MixColumns datapath.
//   AES_POLY : reduction constant for x^8+x^4+x^3+x+1
//   col_t    : one 32-bit state column, row 0 in the MSB byte
//   xtime    : multiply a byte by x (02) in GF(2^8)
//   gf_mul   : multiply a byte by one of the MixColumns constants
// -----------------------------------------------------------------------------
package aes_pkg;

  localparam logic [7:0] AES_POLY = 8'h1B;

  typedef logic [31:0] col_t;

  // Multiply by x, folding the carried-out bit back in through the polynomial.
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? AES_POLY : 8'h00);
  endfunction

  // Constant multiply built from an xtime chain: a*2, a*4, a*8 then XOR terms.
  // Only the constants MixColumns/InvMixColumns use are supported; any other
  // constant returns zero.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] k);
    logic [7:0] x2;
    logic [7:0] x4;
    logic [7:0] x8;
    logic [7:0] r;
    x2 = xtime(a);
    x4 = xtime(x2);
    x8 = xtime(x4);
    case (k)
      8'h01:   r = a;
      8'h02:   r = x2;
      8'h03:   r = x2 ^ a;
      8'h09:   r = x8 ^ a;
      8'h0B:   r = x8 ^ x2 ^ a;
      8'h0D:   r = x8 ^ x4 ^ a;
      8'h0E:   r = x8 ^ x4 ^ x2;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mix_single_column.sv
// -----------------------------------------------------------------------------
// mix_single_column
// Combinational MixColumns / InvMixColumns on one 32-bit column.
//   col_in  : input column, a0 in bits [31:24]
//   inv     : 0 = forward MixColumns, 1 = InvMixColumns
//   col_out : transformed column, r0 in bits [31:24]
// -----------------------------------------------------------------------------
module mix_single_column
  import aes_pkg::*;
(
  input  col_t col_in,
  input  logic inv,
  output col_t col_out
);

  logic [7:0] a0_s;
  logic [7:0] a1_s;
  logic [7:0] a2_s;
  logic [7:0] a3_s;

  assign a0_s = col_in[31:24];
  assign a1_s = col_in[23:16];
  assign a2_s = col_in[15:8];
  assign a3_s = col_in[7:0];

  // Circulant matrix multiply; each output row uses the coefficient row
  // rotated right by its row index.
  always_comb begin
    col_out = 32'h0000_0000;
    if (inv) begin
      col_out[31:24] = gf_mul(a0_s, 8'h0E) ^ gf_mul(a1_s, 8'h0B) ^ gf_mul(a2_s, 8'h0D) ^ gf_mul(a3_s, 8'h09);
      col_out[23:16] = gf_mul(a0_s, 8'h09) ^ gf_mul(a1_s, 8'h0E) ^ gf_mul(a2_s, 8'h0B) ^ gf_mul(a3_s, 8'h0D);
      col_out[15:8]  = gf_mul(a0_s, 8'h0D) ^ gf_mul(a1_s, 8'h09) ^ gf_mul(a2_s, 8'h0E) ^ gf_mul(a3_s, 8'h0B);
      col_out[7:0]   = gf_mul(a0_s, 8'h0B) ^ gf_mul(a1_s, 8'h0D) ^ gf_mul(a2_s, 8'h09) ^ gf_mul(a3_s, 8'h0E);
    end else begin
      col_out[31:24] = gf_mul(a0_s, 8'h02) ^ gf_mul(a1_s, 8'h03) ^ a2_s ^ a3_s;
      col_out[23:16] = a0_s ^ gf_mul(a1_s, 8'h02) ^ gf_mul(a2_s, 8'h03) ^ a3_s;
      col_out[15:8]  = a0_s ^ a1_s ^ gf_mul(a2_s, 8'h02) ^ gf_mul(a3_s, 8'h03);
      col_out[7:0]   = gf_mul(a0_s, 8'h03) ^ a1_s ^ a2_s ^ gf_mul(a3_s, 8'h02);
    end
  end

endmodule

// File: rtl/mix_column.sv
// -----------------------------------------------------------------------------
// mix_column
// Registered MixColumns / InvMixColumns over a full 128-bit AES state,
// one state per cycle, one cycle of latency.
//   clk       : rising-edge clock
//   rst_n     : synchronous active-low reset
//   in_valid  : in_data / in_inv valid this cycle
//   in_inv    : 0 = MixColumns, 1 = InvMixColumns (per transfer)
//   in_data   : input state, column 0 at bits [127:96]
//   out_valid : out_data carries a fresh result
//   out_data  : transformed state (held across idle cycles)
// -----------------------------------------------------------------------------
module mix_column
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic         in_inv,
  input  logic [127:0] in_data,
  output logic         out_valid,
  output logic [127:0] out_data
);

  logic [127:0] mixed_s;
  logic         out_valid_r;
  logic [127:0] out_data_r;

  // Four independent column mixers; no byte crosses a column boundary.
  for (genvar c = 0; c < 4; c++) begin : g_col
    mix_single_column u_col (
      .col_in  (in_data[127-32*c -: 32]),
      .inv     (in_inv),
      .col_out (mixed_s[127-32*c -: 32])
    );
  end

  // Output register: reset wins; idle cycles drop valid but keep the data.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      out_data_r  <= 128'h0;
    end else if (in_valid) begin
      out_valid_r <= 1'b1;
      out_data_r  <= mixed_s;
    end else begin
      out_valid_r <= 1'b0;
    end
  end

  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;

endmodule

// File: tb/tb_mix_column.sv
// -----------------------------------------------------------------------------
// tb_mix_column
// Self-checking bench: directed FIPS-197 vectors plus randomized traffic,
// compared against a matrix-multiply reference model using a generic
// shift-and-add GF(2^8) multiplier.
// -----------------------------------------------------------------------------
module tb_mix_column;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_inv;
  logic [127:0] in_data;
  logic         out_valid;
  logic [127:0] out_data;

  int checks_cnt;
  int fail_cnt;

  logic         exp_valid;
  logic [127:0] exp_data;

  mix_column dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_inv    (in_inv),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_data  (out_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Generic GF(2^8) multiply (Russian peasant).
  function automatic logic [7:0] ref_gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    logic [7:0] bb;
    p = 8'h00;
    aa = a;
    bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      if (aa[7]) aa = (aa << 1) ^ 8'h1B;
      else       aa = aa << 1;
      bb = bb >> 1;
    end
    return p;
  endfunction

  // Whole-state mix: each column times the circulant matrix.
  function automatic logic [127:0] ref_mix(input logic [127:0] s, input logic inv);
    logic [7:0]   coef [4];
    logic [7:0]   a [4];
    logic [7:0]   r;
    logic [127:0] o;
    if (inv) begin
      coef[0] = 8'h0E; coef[1] = 8'h0B; coef[2] = 8'h0D; coef[3] = 8'h09;
    end else begin
      coef[0] = 8'h02; coef[1] = 8'h03; coef[2] = 8'h01; coef[3] = 8'h01;
    end
    o = 128'h0;
    for (int c = 0; c < 4; c++) begin
      for (int j = 0; j < 4; j++) a[j] = s[127 - 32*c - 8*j -: 8];
      for (int row = 0; row < 4; row++) begin
        r = 8'h00;
        for (int j = 0; j < 4; j++) r = r ^ ref_gmul(coef[(j - row + 4) % 4], a[j]);
        o[127 - 32*c - 8*row -: 8] = r;
      end
    end
    return o;
  endfunction

  task automatic check_eq(input string tag, input logic [127:0] observed, input logic [127:0] expected);
    checks_cnt++;
    if (observed !== expected) begin
      fail_cnt++;
      $display("FAIL %s observed=%032h expected=%032h", tag, observed, expected);
    end
  endtask

  // One clock: drive inputs, take the edge, update the model, compare.
  task automatic cycle(input logic rst, input logic v, input logic inv, input logic [127:0] d, input string tag);
    rst_n    = rst;
    in_valid = v;
    in_inv   = inv;
    in_data  = d;
    @(posedge clk);
    #1;
    if (!rst) begin
      exp_valid = 1'b0;
      exp_data  = 128'h0;
    end else if (v) begin
      exp_valid = 1'b1;
      exp_data  = ref_mix(d, inv);
    end else begin
      exp_valid = 1'b0;
    end
    check_eq({tag, "_valid"}, {127'h0, out_valid}, {127'h0, exp_valid});
    check_eq({tag, "_data"}, out_data, exp_data);
  endtask

  localparam logic [127:0] V_FIPS = 128'hDB135345_F20A225C_C6C6C6C6_D4D4D4D5;
  localparam logic [127:0] V_COL0 = 128'h2D26314C_01010101_01010101_01010101;
  localparam logic [127:0] V_RND1 = 128'hD4BF5D30_E0B452AE_B84111F1_1E2798E5;
  localparam logic [127:0] R_RND1 = 128'h046681E5_E0CB199A_48F8D37A_2806264C;

  initial begin
    logic [127:0] rnd;
    logic [127:0] held;
    checks_cnt = 0;
    fail_cnt   = 0;
    exp_valid  = 1'b0;
    exp_data   = 128'h0;
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    in_inv     = 1'b0;
    in_data    = 128'h0;
    @(negedge clk);

    // Reset with valid input present
    cycle(1'b0, 1'b1, 1'b0, V_FIPS, "rst0");
    cycle(1'b0, 1'b1, 1'b1, V_RND1, "rst1");
    check_eq("rst_zero", out_data, 128'h0);

    // Uniform columns are fixed points
    cycle(1'b1, 1'b1, 1'b0, 128'h01010101_01010101_01010101_01010101, "unif1");
    check_eq("unif1_const", out_data, 128'h01010101_01010101_01010101_01010101);
    cycle(1'b1, 1'b1, 1'b0, 128'h01010101_02020202_01010101_01010101, "unif2");
    check_eq("unif2_const", out_data, 128'h01010101_02020202_01010101_01010101);

    // FIPS column vectors
    cycle(1'b1, 1'b1, 1'b0, V_FIPS, "fips");
    check_eq("fips_const", out_data, 128'h8E4DA1BC_9FDC589D_C6C6C6C6_D5D5D7D6);
    cycle(1'b1, 1'b1, 1'b0, V_COL0, "col0");
    check_eq("col0_const", out_data, 128'h4D7EBDF8_01010101_01010101_01010101);

    // Round-1 vector and its inverse
    cycle(1'b1, 1'b1, 1'b0, V_RND1, "rnd1f");
    check_eq("rnd1f_const", out_data, R_RND1);
    cycle(1'b1, 1'b1, 1'b1, R_RND1, "rnd1i");
    check_eq("rnd1i_const", out_data, V_RND1);

    // Streaming with alternating mode, then idle hold
    cycle(1'b1, 1'b1, 1'b0, V_FIPS, "strm0");
    cycle(1'b1, 1'b1, 1'b1, V_COL0, "strm1");
    cycle(1'b1, 1'b1, 1'b0, V_RND1, "strm2");
    check_eq("strm2_const", out_data, R_RND1);
    cycle(1'b1, 1'b0, 1'b1, V_FIPS, "idle0");
    check_eq("idle_hold", out_data, R_RND1);
    cycle(1'b1, 1'b0, 1'b0, V_COL0, "idle1");

    // Reset the cycle after a valid input drops the result
    cycle(1'b1, 1'b1, 1'b0, V_FIPS, "pre_rst");
    cycle(1'b0, 1'b1, 1'b0, V_RND1, "mid_rst");
    check_eq("mid_rst_zero", out_data, 128'h0);
    cycle(1'b1, 1'b0, 1'b0, V_RND1, "post_rst_idle");
    cycle(1'b1, 1'b1, 1'b0, V_RND1, "post_rst");
    check_eq("post_rst_const", out_data, R_RND1);

    // Randomized traffic with occasional reset
    for (int i = 0; i < 300; i++) begin
      rnd = {$urandom, $urandom, $urandom, $urandom};
      cycle(($urandom_range(0, 19) != 0), ($urandom_range(0, 3) != 0),
            $urandom_range(0, 1) == 1, rnd, "rand");
    end

    // Forward then inverse round trip on random states
    for (int i = 0; i < 20; i++) begin
      rnd = {$urandom, $urandom, $urandom, $urandom};
      cycle(1'b1, 1'b1, 1'b0, rnd, "rt_fwd");
      held = out_data;
      cycle(1'b1, 1'b1, 1'b1, held, "rt_inv");
      check_eq("roundtrip", out_data, rnd);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
    $finish;
  end

endmodule

// File: doc/mix_column.md
Name: mix_column

Overview:
- Registered AES MixColumns / InvMixColumns stage for a full 128-bit state.
- Sits in the AES round datapath after ShiftRows on encryption, and before InvShiftRows on decryption.
- Processes one state per cycle, with a 1-cycle latency and a valid-qualified streaming interface (no backpressure).

Parameters:
- None. The state width is fixed at 128 bits.
- Byte order is fixed by the AES standard (FIPS-197).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  in_data and in_inv are valid this cycle.
- in_inv  input  1  0 = MixColumns (forward), 1 = InvMixColumns.
- in_data  input  128  input state.
- out_valid  output  1  out_data holds a result.
- out_data  output  128  transformed state.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is synchronous and active-low.
- Reset: when rst_n=0 at a rising edge, out_valid<=0 and out_data<=128'h0. This has priority over any in_valid that cycle.
- State layout: byte k (k=0..15) = in_data[127-8k -: 8]. Column c (c=0..3) = bytes 4c..4c+3 = in_data[127-32c -: 32]. Its first byte (a0) is row 0, at the MSB end.
- Column arithmetic is in GF(2^8) with polynomial x^8+x^4+x^3+x+1.
- xtime(a) = {a[6:0],1'b0} XOR (a[7] ? 8'h1B : 8'h00).
- Forward transform per column:
  - r0=2a0^3a1^a2^a3
  - r1=a0^2a1^3a2^a3
  - r2=a0^a1^2a2^3a3
  - r3=3a0^a1^a2^2a3
- Inverse transform: coefficient rows {0E,0B,0D,09}, rotated right by one per output row (r0=0E a0^0B a1^0D a2^09 a3, etc.).
- Mixing scope: all four columns are transformed independently and in parallel. There is no mixing across columns.
- Latency: when in_valid=1 at edge N (and rst_n=1), out_data holds the result and out_valid=1 after edge N.
- Throughput: one state per cycle. Back-to-back inputs produce back-to-back outputs.
- Idle cycles: when in_valid=0 at an edge, out_valid<=0 and out_data holds its previous value. Out_data is not cleared.
- Mode select: in_inv is sampled together with in_data, per transfer. The mode may change on every cycle.
- Reset mid-stream: any result in flight is discarded. The first valid input after rst_n returns high is processed normally.
- Datapath: combinational from in_data to the register input. No internal state other than the output registers.

Decomposition:
- Package aes_pkg:
  - AES_POLY = 8'h1B.
  - Function xtime(byte).
  - Function gf_mul(byte, const), for constants 02, 03, 09, 0B, 0D, 0E, built from xtime chains.
  - Typedef for the 32-bit column word.
- Sub-module mix_single_column:
  - Purely combinational. Inputs: 32-bit column and inv; output: 32-bit column.
  - Instantiated four times inside mix_column; the output register lives in the top.

Test Plan:
- Uniform state, forward: in_data=128'h01010101_01010101_01010101_01010101, in_inv=0 -> next cycle out_data identical to in_data, out_valid=1. Then 128'h01010101_02020202_01010101_01010101 -> identical (every uniform column is a fixed point).
- FIPS-197 column vectors, forward, one column per slot:
  - Input 128'hDB135345_F20A225C_C6C6C6C6_D4D4D4D5 -> out_data=128'h8E4DA1BC_9FDC589D_C6C6C6C6_D5D5D7D6.
  - Input 128'h2D26314C_01010101_01010101_01010101 -> column 0 = 4D7EBDF8, other columns unchanged.
- FIPS-197 round-1 vector: 128'hD4BF5D30_E0B452AE_B84111F1_1E2798E5, inv=0 -> 128'h046681E5_E0CB199A_48F8D37A_2806264C. The same output fed back with inv=1 -> the original input.
- Streaming and mode toggle: the three vectors above presented on consecutive cycles with alternating in_inv -> three consecutive outputs, each 1 cycle later, each matching its own mode. Follow with in_valid=0 -> out_valid=0 and out_data held.
- Reset:
  - rst_n=0 for 2 cycles with in_valid=1 -> out_valid=0, out_data=0.
  - Reset asserted on the cycle after a valid input -> that result is dropped.
  - Release reset, then one valid input -> correct result after 1 cycle.
